accumulator_control_unit: RTL and testbench

- Fetch/decode/execute sequencer for the 8-bit accumulator datapath; sits directly upstream of the accumulator and drives its loadAcc strobe.
- Also selects the ALU operation that forms the accumulator's dataIn, and drives the 16x8 synchronous program/data memory.
- Instruction format: opcode = ir[7:4], operand address = ir[3:0].

---
 rtl/accumulator_control_unit_pkg.sv | 52 +++++
 rtl/accumulator_control_unit_instr_decoder.sv | 31 +++
 rtl/accumulator_control_unit.sv | 120 ++++++++++++
 tb/tb_accumulator_control_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_control_unit_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, ALU codes, FSM states.
// Pure declarations, no logic or latency.
// No flow control; consumers decode these constants combinationally.
package accumulator_control_unit_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Opcodes live in ir[7:4]; B-E are unassigned and behave as NOP.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ALU_PASS = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_NOT  = 3'b110
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEMLOAD = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  // Instruction class flags plus the ALU function the instruction needs.
  typedef struct packed {
    logic    is_mem_alu;
    logic    is_store;
    logic    is_not;
    logic    is_jmp;
    logic    is_jz;
    logic    is_halt;
    alu_op_e alu_op;
  } dec_t;

endpackage

// File: rtl/accumulator_control_unit_instr_decoder.sv
// Opcode classifier: maps ir[7:4] to instruction class flags and ALU function.
// Purely combinational, zero cycles.
// No flow control; output follows the opcode input.
module instr_decoder
  import accumulator_control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  // Classify the opcode; unlisted codes fall through as NOP (all flags clear).
  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_PASS;
    case (opcode)
      OP_LDA: begin dec.is_mem_alu = 1'b1; dec.alu_op = ALU_PASS; end
      OP_ADD: begin dec.is_mem_alu = 1'b1; dec.alu_op = ALU_ADD;  end
      OP_SUB: begin dec.is_mem_alu = 1'b1; dec.alu_op = ALU_SUB;  end
      OP_AND: begin dec.is_mem_alu = 1'b1; dec.alu_op = ALU_AND;  end
      OP_OR:  begin dec.is_mem_alu = 1'b1; dec.alu_op = ALU_OR;   end
      OP_XOR: begin dec.is_mem_alu = 1'b1; dec.alu_op = ALU_XOR;  end
      OP_STA: dec.is_store = 1'b1;
      OP_NOT: begin dec.is_not = 1'b1; dec.alu_op = ALU_NOT; end
      OP_JMP: dec.is_jmp  = 1'b1;
      OP_JZ:  dec.is_jz   = 1'b1;
      OP_HLT: dec.is_halt = 1'b1;
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/accumulator_control_unit.sv
// Fetch/decode/execute sequencer driving memory strobes, ALU select and accumulator load.
// 3 cycles per instruction, 4 for memory-operand ALU ops; HALT is sticky until reset.
// No backpressure: memory is assumed to answer one cycle after memRead.
module accumulator_control_unit
  import accumulator_control_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [DATA_W-1:0] memData,
  input  logic              accZero,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRead,
  output logic              memWrite,
  output logic              loadAcc,
  output logic [2:0]        aluOp,
  output logic [ADDR_W-1:0] pcOut,
  output logic [DATA_W-1:0] irOut,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic              load_acc;
  alu_op_e           alu_op;
  logic              halt;
  dec_t              dec;

  instr_decoder u_dec (
    .opcode (ir_q[DATA_W-1 -: 4]),
    .dec    (dec)
  );

  // State, PC and IR registers; async reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic and Moore outputs decoded from state and IR.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    load_acc  = 1'b0;
    alu_op    = ALU_PASS;
    halt      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_addr = pc_q;
        mem_read = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = memData;
        pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (dec.is_mem_alu) begin
          mem_addr = ir_q[ADDR_W-1:0];
          mem_read = 1'b1;
          state_d  = ST_MEMLOAD;
        end else if (dec.is_store) begin
          mem_addr  = ir_q[ADDR_W-1:0];
          mem_write = 1'b1;
        end else if (dec.is_not) begin
          alu_op   = ALU_NOT;
          load_acc = 1'b1;
        end else if (dec.is_jmp) begin
          pc_d = ir_q[ADDR_W-1:0];
        end else if (dec.is_jz) begin
          if (accZero) pc_d = ir_q[ADDR_W-1:0];
        end else if (dec.is_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_MEMLOAD: begin
        // Operand read in EXECUTE is on memData now; address held for the datapath.
        mem_addr = ir_q[ADDR_W-1:0];
        load_acc = 1'b1;
        alu_op   = dec.alu_op;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        halt = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, independent of the clock.
  assign memAddr  = resetN ? mem_addr : '0;
  assign memRead  = resetN & mem_read;
  assign memWrite = resetN & mem_write;
  assign loadAcc  = resetN & load_acc;
  assign aluOp    = resetN ? alu_op : ALU_PASS;
  assign halted   = resetN & halt;
  assign pcOut    = pc_q;
  assign irOut    = ir_q;

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Bench for accumulator_control_unit with memory and accumulator models around it.
// Expected bus events come from an instruction-level interpreter into a scoreboard queue.
// A negedge monitor pops and compares whenever a strobe is presented.
module tb_accumulator_control_unit;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] memData;
  logic       accZero;
  logic [3:0] memAddr;
  logic       memRead, memWrite, loadAcc;
  logic [2:0] aluOp;
  logic [3:0] pcOut;
  logic [7:0] irOut;
  logic       halted;

  always #5 clk = ~clk;

  accumulator_control_unit dut (
    .clk      (clk),
    .resetN   (resetN),
    .memData  (memData),
    .accZero  (accZero),
    .memAddr  (memAddr),
    .memRead  (memRead),
    .memWrite (memWrite),
    .loadAcc  (loadAcc),
    .aluOp    (aluOp),
    .pcOut    (pcOut),
    .irOut    (irOut),
    .halted   (halted)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- environment: memory + accumulator ----------------
  logic [7:0] img [16];
  logic [7:0] mem [16];
  logic [7:0] rdata;
  logic [7:0] acc;

  assign memData = rdata;
  assign accZero = (acc == 8'h00);

  always @(posedge clk) begin
    if (!resetN) mem <= img;
    else if (memWrite) mem[memAddr] <= acc;
    if (memRead) rdata <= mem[memAddr];
  end

  function automatic logic [7:0] alu(logic [2:0] code, logic [7:0] a, logic [7:0] b);
    case (code)
      3'b000: return b;
      3'b001: return a + b;
      3'b010: return a - b;
      3'b011: return a & b;
      3'b100: return a | b;
      3'b101: return a ^ b;
      3'b110: return ~a;
      default: return a;
    endcase
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) acc <= 8'h00;
    else if (loadAcc) acc <= alu(aluOp, acc, memData);
  end

  int cyc;
  always @(posedge clk) begin
    if (!resetN) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int         kind;   // 0 read, 1 write, 2 accumulator load
    int         cyc;
    logic [3:0] addr;
    logic [2:0] op;
    logic [7:0] data;
    bit         achk;
  } ev_t;

  ev_t        q[$];
  int         end_cyc;
  bit         active = 1'b0;
  bit         exp_halt;
  logic [7:0] exp_acc;

  function automatic void push_ev(int k, int c, logic [3:0] a, logic [2:0] o, logic [7:0] d, bit ac);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.op = o; e.data = d; e.achk = ac;
    q.push_back(e);
  endfunction

  // Instruction-level interpreter: executes k instructions from img and lists the bus events.
  task automatic build_model(input int k);
    logic [7:0] m [16];
    logic [7:0] a, ir, b;
    logic [3:0] pc, ad, op;
    int t;
    m = img; pc = 4'd0; t = 0; a = 8'h00;
    exp_halt = 1'b0;
    q.delete();
    for (int n = 0; n < k; n++) begin
      push_ev(0, t, pc, 3'd0, 8'h00, 1'b1);
      ir = m[pc];
      pc = pc + 4'd1;
      op = ir[7:4];
      ad = ir[3:0];
      if (op == 4'h1 || (op >= 4'h3 && op <= 4'h7)) begin
        b = m[ad];
        push_ev(0, t + 2, ad, 3'd0, 8'h00, 1'b1);
        case (op)
          4'h1: begin a = b;     push_ev(2, t + 3, ad, 3'b000, a, 1'b1); end
          4'h3: begin a = a + b; push_ev(2, t + 3, ad, 3'b001, a, 1'b1); end
          4'h4: begin a = a - b; push_ev(2, t + 3, ad, 3'b010, a, 1'b1); end
          4'h5: begin a = a & b; push_ev(2, t + 3, ad, 3'b011, a, 1'b1); end
          4'h6: begin a = a | b; push_ev(2, t + 3, ad, 3'b100, a, 1'b1); end
          default: begin a = a ^ b; push_ev(2, t + 3, ad, 3'b101, a, 1'b1); end
        endcase
        t += 4;
      end else if (op == 4'h2) begin
        push_ev(1, t + 2, ad, 3'd0, a, 1'b1);
        m[ad] = a;
        t += 3;
      end else if (op == 4'h8) begin
        a = ~a;
        push_ev(2, t + 2, 4'd0, 3'b110, a, 1'b0);
        t += 3;
      end else if (op == 4'h9) begin
        pc = ad; t += 3;
      end else if (op == 4'hA) begin
        if (a == 8'h00) pc = ad;
        t += 3;
      end else if (op == 4'hF) begin
        exp_halt = 1'b1;
        t += 3;
        break;
      end else begin
        t += 3;
      end
    end
    end_cyc = t;
    exp_acc = a;
  endtask

  bit         pend = 1'b0;
  logic [7:0] pend_val;

  // Monitor: compare every presented strobe with the next expected event.
  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (resetN) begin
      if (pend) begin
        check("acc_after_load", acc, pend_val);
        pend = 1'b0;
      end
      if (active) check("rd_wr_exclusive", memRead & memWrite, 0);
      if (active && cyc < end_cyc && (memRead || memWrite || loadAcc)) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {memRead, memWrite, loadAcc}, 0);
        end else begin
          e = q.pop_front();
          kind = memRead ? 0 : (memWrite ? 1 : 2);
          check("event_kind", kind, e.kind);
          check("event_cycle", cyc, e.cyc);
          if (e.kind == 0) begin
            check("read_addr", memAddr, e.addr);
          end else if (e.kind == 1) begin
            check("write_addr", memAddr, e.addr);
            check("write_data", acc, e.data);
            check("no_load_in_store", loadAcc, 0);
          end else begin
            check("alu_op", aluOp, e.op);
            if (e.achk) check("load_addr", memAddr, e.addr);
            pend     = 1'b1;
            pend_val = e.data;
          end
        end
      end
    end
  end

  // Reset, run k instructions, then confirm all events seen and final state.
  task automatic run_prog(input int k);
    resetN = 1'b0;
    active = 1'b0;
    build_model(k);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {memRead, memWrite, loadAcc, halted}, 0);
    check("rst_memaddr", memAddr, 0);
    check("rst_aluop", aluOp, 0);
    check("rst_pc", pcOut, 0);
    check("rst_ir", irOut, 0);
    @(posedge clk);
    #2 resetN = 1'b1;
    active = 1'b1;
    #1;
    check("first_fetch_rd", memRead, 1);
    check("first_fetch_addr", memAddr, 0);
    repeat (end_cyc) @(posedge clk);
    #6;
    check("queue_drained", q.size(), 0);
    check("halted_end", halted, exp_halt);
    check("acc_end", acc, exp_acc);
    active = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  initial begin
    resetN = 1'b0;
    clear_img();

    // LDA E ; ADD F  -> AA + 05 = AF
    img[0] = 8'h1E; img[1] = 8'h3F; img[14] = 8'hAA; img[15] = 8'h05;
    run_prog(2);
    check("lda_add_result", acc, 8'hAF);

    // LDA E ; NOT ; STA D -> writes 55 to D
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h80; img[2] = 8'h2D; img[14] = 8'hAA;
    run_prog(3);
    check("sta_mem_d", mem[13], 8'h55);

    // JZ taken with acc zero
    clear_img();
    img[0] = 8'hA5;
    run_prog(2);

    // JZ not taken with acc nonzero
    clear_img();
    img[0] = 8'h1E; img[1] = 8'hA5; img[14] = 8'hAA;
    run_prog(3);

    // JMP F, NOP at F, wraps back to 0
    clear_img();
    img[0] = 8'h9F; img[15] = 8'h00;
    run_prog(3);

    // HLT at address 2, sticky, then async reset
    clear_img();
    img[2] = 8'hF0;
    run_prog(3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_sticky", halted, 1);
      check("halt_quiet", {memRead, memWrite, loadAcc}, 0);
    end
    @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    check("async_rst_halted", halted, 0);
    check("async_rst_pc", pcOut, 0);

    // Random programs against the interpreter
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      run_prog(20);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
